cod2de5_display_mux: RTL and testbench



---
 rtl/cod2de5_display_mux.sv | 157 +++++++++++++++
 tb/tb_cod2de5_display_mux.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/cod2de5_display_mux.sv
// cod2de5_display_mux
//   Accepts 2-of-5 code words (weights 7-4-2-1-0) over a valid/ready
//   handshake and checks them. Accepted words go into an N_DIGITS-deep
//   shift buffer that drives a time-multiplexed common-anode 7-segment
//   display. Invalid words are counted in a saturating counter.
//
//   Optional feature macro: COD2DE5_ERR_SYMBOL_EN
//     defined   - invalid words shift into the buffer and show "E"
//     undefined - invalid words are only counted
//
// Ports:
//   clk       system clock, all state on rising edge
//   rst       synchronous active-high reset
//   clr       synchronous clear of buffer and error counter (scan kept)
//   in_code   code word, bit[4..0] = weights 7,4,2,1,0
//   in_valid  in_code valid this cycle
//   in_ready  block accepts a word this cycle (!rst && !clr)
//   seg       {g,f,e,d,c,b,a}, active-low
//   an        digit enable, active-low, one-hot-low
//   err_cnt   saturating count of invalid words accepted
module cod2de5_display_mux #(
    parameter int N_DIGITS = 4,
    parameter int SCAN_DIV = 1000,
    parameter int ERR_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic [4:0]          in_code,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [6:0]          seg,
    output logic [N_DIGITS-1:0] an,
    output logic [ERR_W-1:0]    err_cnt
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

`ifdef COD2DE5_ERR_SYMBOL_EN
    localparam bit ERR_SYMBOL_EN = 1'b1;
`else
    localparam bit ERR_SYMBOL_EN = 1'b0;
`endif

    typedef enum logic {KIND_DIGIT, KIND_ERROR} kind_t;

    typedef struct packed {
        logic       used;
        kind_t      kind;
        logic [3:0] value;
    } entry_t;

    entry_t             digits_q [N_DIGITS];
    logic [DIV_W-1:0]   div_q;
    logic [IDX_W-1:0]   idx_q;

    logic               code_ok;
    logic [3:0]         code_val;
    logic               transfer;
    logic               store;
    entry_t             new_entry;

    assign in_ready = !rst && !clr;
    assign transfer = in_valid && in_ready;
    // Invalid words only enter the buffer when the error symbol is enabled.
    assign store    = transfer && (code_ok || ERR_SYMBOL_EN);

    always_comb begin
        code_ok  = 1'b1;
        code_val = 4'd0;
        unique case (in_code)
            5'b11000: code_val = 4'd0;
            5'b00011: code_val = 4'd1;
            5'b00101: code_val = 4'd2;
            5'b00110: code_val = 4'd3;
            5'b01001: code_val = 4'd4;
            5'b01010: code_val = 4'd5;
            5'b01100: code_val = 4'd6;
            5'b10001: code_val = 4'd7;
            5'b10010: code_val = 4'd8;
            5'b10100: code_val = 4'd9;
            default:  code_ok  = 1'b0;
        endcase
    end

    always_comb begin
        new_entry.used  = 1'b1;
        new_entry.kind  = code_ok ? KIND_DIGIT : KIND_ERROR;
        new_entry.value = code_val;
    end

    function automatic logic [6:0] glyph(input entry_t e);
        logic [6:0] g;
        g = 7'h7F;
        if (e.used && e.kind == KIND_ERROR) begin
            g = 7'h06;
        end else if (e.used) begin
            unique case (e.value)
                4'd0:    g = 7'h40;
                4'd1:    g = 7'h79;
                4'd2:    g = 7'h24;
                4'd3:    g = 7'h30;
                4'd4:    g = 7'h19;
                4'd5:    g = 7'h12;
                4'd6:    g = 7'h02;
                4'd7:    g = 7'h78;
                4'd8:    g = 7'h00;
                4'd9:    g = 7'h10;
                default: g = 7'h7F;
            endcase
        end
        return g;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_DIGITS; i++) begin
                digits_q[i] <= '0;
            end
            err_cnt <= '0;
            div_q   <= '0;
            idx_q   <= '0;
            seg     <= 7'h7F;
            an      <= '1;
        end else begin
            if (div_q == DIV_W'(SCAN_DIV - 1)) begin
                div_q <= '0;
                idx_q <= (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
            end else begin
                div_q <= div_q + DIV_W'(1);
            end

            // Display outputs follow the pre-edge index and buffer contents.
            an  <= ~(N_DIGITS'(1) << idx_q);
            seg <= glyph(digits_q[idx_q]);

            if (clr) begin
                for (int unsigned i = 0; i < N_DIGITS; i++) begin
                    digits_q[i] <= '0;
                end
                err_cnt <= '0;
            end else if (transfer) begin
                if (!code_ok && err_cnt != '1) begin
                    err_cnt <= err_cnt + ERR_W'(1);
                end
                if (store) begin
                    for (int unsigned i = N_DIGITS - 1; i >= 1; i--) begin
                        digits_q[i] <= digits_q[i-1];
                    end
                    digits_q[0] <= new_entry;
                end
            end
        end
    end

endmodule

// File: tb/tb_cod2de5_display_mux.sv
module tb_cod2de5_display_mux;

    localparam int N        = 4;
    localparam int SDIV     = 2;
    localparam int EW       = 2;
    localparam int ERR_MAX  = (1 << EW) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         clr;
    logic [4:0]   in_code;
    logic         in_valid;
    logic         in_ready;
    logic [6:0]   seg;
    logic [N-1:0] an;
    logic [EW-1:0] err_cnt;

    cod2de5_display_mux #(
        .N_DIGITS (N),
        .SCAN_DIV (SDIV),
        .ERR_W    (EW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_code  (in_code),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .seg      (seg),
        .an       (an),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: -1 unused, 0..9 digit, 10 error symbol.
    int m_buf [N];
    int m_err;
    int m_cyc;   // edges since reset release

    logic [6:0] glyph_tab [11] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                   7'h12, 7'h02, 7'h78, 7'h00, 7'h10, 7'h06};
    logic [4:0] code_tab  [10] = '{5'b11000, 5'b00011, 5'b00101, 5'b00110, 5'b01001,
                                   5'b01010, 5'b01100, 5'b10001, 5'b10010, 5'b10100};

    function automatic int model_decode(input logic [4:0] c);
        int s;
        if ($countones(c) != 2) return -1;
        s = 7 * c[4] + 4 * c[3] + 2 * c[2] + 1 * c[1];
        return (s == 11) ? 0 : s;
    endfunction

    function automatic logic [6:0] model_glyph(input int e);
        if (e < 0) return 7'h7F;
        return glyph_tab[e];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_shift(input int v);
        for (int i = N - 1; i >= 1; i--) m_buf[i] = m_buf[i-1];
        m_buf[0] = v;
    endtask

    // One clock: drive inputs, predict outputs, clock, compare.
    task automatic step(input logic r, input logic c, input logic v, input logic [4:0] code);
        logic [6:0]   e_seg;
        logic [N-1:0] e_an;
        int           idx;
        int           d;
        rst = r; clr = c; in_valid = v; in_code = code;
        #1;
        check("in_ready", 32'(in_ready), 32'(!r && !c));
        if (r) begin
            e_seg = 7'h7F;
            e_an  = '1;
            foreach (m_buf[i]) m_buf[i] = -1;
            m_err = 0;
            m_cyc = 0;
        end else begin
            idx   = (m_cyc / SDIV) % N;
            e_an  = '1;
            e_an[idx] = 1'b0;
            e_seg = model_glyph(m_buf[idx]);
            m_cyc++;
            if (c) begin
                foreach (m_buf[i]) m_buf[i] = -1;
                m_err = 0;
            end else if (v) begin
                d = model_decode(code);
                if (d >= 0) begin
                    model_shift(d);
                end else begin
                    if (m_err < ERR_MAX) m_err++;
`ifdef COD2DE5_ERR_SYMBOL_EN
                    model_shift(10);
`endif
                end
            end
        end
        @(posedge clk);
        #1;
        check("seg", 32'(seg), 32'(e_seg));
        check("an", 32'(an), 32'(e_an));
        check("err_cnt", 32'(err_cnt), 32'(m_err));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 5'b00000);
    endtask

    initial begin
        int r;
        logic [4:0] code;
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_code = '0;
        foreach (m_buf[i]) m_buf[i] = -1;
        m_err = 0;
        m_cyc = 0;
        @(posedge clk);
        #1;

        // Reset held three cycles, then release with blank digit 0 scanned.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 5'b00000);
        idle(2 * N * SDIV);

        // Digit fill 0,1,2,3 back-to-back, then a full frame of scanning.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, code_tab[i]);
        idle(2 * N * SDIV);

        // Invalid words: three ones, then all zeros.
        step(1'b0, 1'b0, 1'b1, 5'b11100);
        step(1'b0, 1'b0, 1'b1, 5'b00000);
        idle(N * SDIV);

        // Saturation of the 2-bit counter.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 5'b11111);
        idle(N * SDIV);

        // clr beats a simultaneous valid 9.
        step(1'b0, 1'b1, 1'b1, 5'b10100);
        idle(N * SDIV);

        // Overflow: words 1..6, only 6,5,4,3 remain.
        for (int i = 1; i <= 6; i++) step(1'b0, 1'b0, 1'b1, code_tab[i]);
        idle(2 * N * SDIV);

        // Reset mid-frame with a word in flight.
        step(1'b1, 1'b0, 1'b1, code_tab[7]);
        idle(N * SDIV);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if ($urandom_range(0, 1) == 0) code = code_tab[$urandom_range(0, 9)];
            else                           code = 5'($urandom);
            if (r < 2)       step(1'b1, 1'b0, 1'($urandom), code);
            else if (r < 6)  step(1'b0, 1'b1, 1'($urandom), code);
            else if (r < 76) step(1'b0, 1'b0, 1'b1, code);
            else             step(1'b0, 1'b0, 1'b0, code);
        end
        idle(N * SDIV);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
